// File: rtl/fir_ctrl_if.sv
// Sample-in / result-out valid-ready streams for the FIR controller.
interface fir_ctrl_if #(
    parameter int DWIDTH = 14,
    parameter int OWIDTH = 26
);
    logic              s_valid;
    logic [DWIDTH-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [OWIDTH-1:0] m_data;
    logic              m_ready;

    // Controller side: consumes samples, produces results.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    // Environment side: produces samples, consumes results.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/fir_ctrl.sv
// Sequencing/config controller for the 37-tap symmetric FIR: coefficient bank
// with mirroring, sample window with priming, and a registered result stage.
module fir_ctrl #(
    parameter int DWIDTH = 14,
    parameter int CWIDTH = 11,
    parameter int NTAP   = 37,
    parameter int OWIDTH = 26
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         cfg_wr,
    input  logic [5:0]                   cfg_addr,
    input  logic [CWIDTH-1:0]            cfg_data,
    output logic                         cfg_err,
    output logic [NTAP-1:0][DWIDTH:0]    win,
    output logic [NTAP-1:0][CWIDTH-1:0]  coeff,
    output logic                         fir_en,
    input  logic [OWIDTH-1:0]            fir_dout,
    output logic                         busy,
    fir_ctrl_if.slave                    bus
);
    localparam int NUNIQ = (NTAP + 1) / 2;

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t                         state, state_nxt;
    logic [NUNIQ-1:0][CWIDTH-1:0]   c;
    logic [5:0]                     fill_cnt;
    logic                           cap;
    logic                           m_valid;
    logic [OWIDTH-1:0]              m_data;
    logic                           active;
    logic                           accept;
    logic                           last_fill;
    logic                           enter_prime;
    logic                           cfg_ok;

    assign active      = (state != IDLE);
    assign bus.s_ready = active && !cap && (!m_valid || bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_fill   = (fill_cnt == 6'(NTAP - 1));
    assign enter_prime = (state == IDLE) && (state_nxt == PRIME);
    assign cfg_ok      = cfg_wr && (state == IDLE) && (cfg_addr < 6'(NUNIQ));
    assign fir_en      = active || cap;
    assign busy        = active;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_data;

    // Tap k and tap NTAP-1-k share one stored coefficient.
    for (genvar k = 0; k < NTAP; k++) begin : g_mirror
        assign coeff[k] = c[(k < NUNIQ) ? k : (NTAP - 1 - k)];
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start && !stop)          state_nxt = PRIME;
            PRIME:   if (stop)                    state_nxt = IDLE;
                     else if (accept && last_fill) state_nxt = RUN;
            RUN:     if (stop)                    state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: coefficient bank and window are reset because a reset must discard them.
            c        <= '0;
            win      <= '0;
            fill_cnt <= '0;
            cap      <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfg_ok;
            for (int k = 0; k < NUNIQ; k++) begin
                if (cfg_ok && (cfg_addr == 6'(k))) c[k] <= cfg_data;
            end

            if (enter_prime) begin
                win      <= '0;
                fill_cnt <= '0;
            end else if (accept) begin
                win <= {win[NTAP-2:0], {bus.s_data[DWIDTH-1], bus.s_data}};
                if (fill_cnt != 6'(NTAP)) fill_cnt <= fill_cnt + 6'd1;
            end

            // The capture runs to completion even if stop lands in the same cycle.
            cap <= accept && ((state == RUN) || ((state == PRIME) && last_fill));

            if (cap) begin
                m_data  <= fir_dout;
                m_valid <= 1'b1;
            end else if (m_valid && bus.m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencing and configuration controller for the 37-tap symmetric FIR datapath. It holds the 19 unique coefficients, mirrors them onto the full 37-entry coefficient bus, and maintains the 37-sample window that feeds the FIR's parallel `din` bus. It also primes the window after start and registers the combinational FIR result into a valid/ready output stage. It sits between the ADC sample stream / register-bus config writes and the `fir` instance.

## Interface
Parameters:
- DWIDTH, 14, sample width (signed); window entries are DWIDTH+1 bits
- CWIDTH, 11, coefficient width (signed)
- NTAP, 37, tap count; odd; unique coefficients = (NTAP+1)/2 = 19
- OWIDTH, 26, FIR result width

Ports:
- CLK  in  1  system clock; one clock
- RST_N  in  1  synchronous, active-low reset
- start  in  1  pulse: begin priming; accepted in IDLE only
- stop  in  1  pulse: return to IDLE
- cfg_wr  in  1  coefficient write strobe
- cfg_addr  in  6  unique coefficient index, 0..18
- cfg_data  in  CWIDTH  coefficient value
- cfg_err  out  1  one-cycle pulse on a rejected write
- s_valid  in  1  sample valid
- s_data  in  DWIDTH  signed sample
- s_ready  out  1  sample accept
- win  out  [NTAP] x (DWIDTH+1)  window to FIR `din`; win[0] newest
- coeff  out  [NTAP] x CWIDTH  to FIR `coeff`
- fir_en  out  1  to FIR `EN`
- fir_dout  in  OWIDTH  FIR result (combinational)
- m_valid  out  1  result valid
- m_data  out  OWIDTH  registered result
- m_ready  in  1  result accept
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PRIME, RUN.
  - IDLE: start -> PRIME.
  - PRIME: on the sample that makes fill_cnt reach NTAP -> RUN.
  - PRIME/RUN: stop -> IDLE.
- start and stop in the same cycle: stop wins. start outside IDLE is ignored.
- Coefficient bank: 19 regs `c[k]`, with coeff[k] = coeff[NTAP-1-k] = c[k] for k ≤ 18.
  - cfg_wr in IDLE with cfg_addr ≤ 18: c[cfg_addr] <= cfg_data.
  - cfg_addr > 18, or cfg_wr in PRIME/RUN: no write; cfg_err = 1 for the next cycle.
  - cfg_wr together with start in IDLE: write lands, start proceeds.
- Window behaviour:
  - On entering PRIME, all win entries and fill_cnt (6 bits) clear to 0.
  - Accepted sample (s_valid & s_ready): win[0] <= sign-extended s_data, win[i] <= win[i-1]; fill_cnt increments, saturating at NTAP.
  - The window holds its value in IDLE.
- Capture flag `cap`:
  - Set on an accepted sample in RUN, or on the NTAP-th sample in PRIME.
  - Next cycle: m_data <= fir_dout, m_valid <= 1, cap <= 0.
  - cap completes even if stop arrives.
- Ready rules:
  - s_ready = (state ∈ {PRIME, RUN}) & !cap & (!m_valid | m_ready).
  - m_valid clears when m_ready & m_valid and no new capture occurs that cycle.
  - A capture in the same cycle as an output handshake keeps m_valid = 1 with new data.
- fir_en = (state ∈ {PRIME, RUN}) | cap.
- busy = (state != IDLE).

## Timing
- Reset (RST_N low at a CLK edge) drives state = IDLE, c[*] = 0, win[*] = 0, fill_cnt = 0, cap = 0, m_valid = 0, m_data = 0, cfg_err = 0.
  - Resulting outputs: s_ready = 0, fir_en = 0, busy = 0, coeff = 0.
  - Reset mid-PRIME/RUN discards the window and any pending output.
- Latency from sample acceptance to m_valid:
  - Sample accepted at edge N: win updates at N.
  - fir_dout settles during cycle N..N+1.
  - m_data/m_valid update at edge N+1.
- Peak throughput: 1 sample per 2 cycles (s_ready low during the cap cycle).
- No m_valid for the first NTAP-1 samples after start. The first result corresponds to the full 37-sample window.
- m_data is stable while m_valid & !m_ready.
- Backpressure: s_ready stays low until the result is taken. Samples are never dropped or overwritten.
- Arithmetic: the block performs no arithmetic on data; fir_dout passes through at full OWIDTH.

## Test plan
- Reset/idle: hold RST_N low 3 cycles, release -> all outputs 0; s_valid = 1 in IDLE -> s_ready = 0, no window change.
- Center tap: write c[18] = 1 (others 0), start, feed samples 1..37 -> m_valid absent for samples 1..36; after sample 37, m_data = 19; sample 38 -> m_data = 20.
- Mirror: c[0] = 2, others 0, feed constant 100 -> first result m_data = 400 (taps 0 and 36); c[5] = -3 alone with constant 100 -> -600.
- Backpressure: during RUN hold m_ready = 0 for 5 cycles -> m_data stable, s_ready = 0; release -> stream resumes with no lost or duplicated result (compare against golden FIR model).
- Config errors: cfg_wr with addr 19 in IDLE -> cfg_err one cycle, c unchanged; cfg_wr addr 3 in RUN -> cfg_err, c[3] unchanged.
- Control corners:
  - stop in the same cycle as an accepted sample in RUN -> IDLE next edge, result still delivered.
  - start + stop together in IDLE -> remains IDLE.
  - RST_N low after 20 samples in PRIME -> fill restarts; 37 new samples are needed before the first m_valid.
